instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Parametrised pipelined instruction fetch stage for the CPU. It holds the fetch program counter and owns a synchronous-read instruction memory with a write port for program loading. Each cycle it presents one registered instruction and its PC to decode, qualified by a valid bit. Decode can stall it, and execute can redirect it on a branch or jump, which also flushes the in-flight fetch.

## Interface
Parameters:
- ADDR_W, 7: instruction address width in words; memory depth is 2**ADDR_W.
- DATA_W, 32: instruction width.
- RESET_PC, 0: fetch address loaded at reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  decode back-pressure; holds the PC and output registers.
- redirect_valid  in  1  branch or jump taken; load redirect_pc and flush.
- redirect_pc  in  ADDR_W  redirect target word address.
- imem_we  in  1  instruction memory write enable (program load).
- imem_waddr  in  ADDR_W  write address.
- imem_wdata  in  DATA_W  write data.
- pc  out  ADDR_W  current fetch address (the address being read this cycle).
- if_valid  out  1  if_instr and if_pc hold a live instruction.
- if_pc  out  ADDR_W  address of if_instr.
- if_instr  out  DATA_W  fetched instruction.
- fetch_count  out  32  number of instructions delivered; saturates at 2**32-1.

## Operation
- Reset (reset low, asynchronous): pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, fetch_count=0. Memory contents are not cleared.
- Priority at each rising edge: redirect_valid, then stall, then normal advance.
- Redirect (redirect_valid=1, regardless of stall):
  - pc <= redirect_pc and if_valid <= 0.
  - if_pc and if_instr hold.
  - fetch_count unchanged.
- Stall (stall=1, redirect_valid=0): pc, if_valid, if_pc, if_instr and fetch_count all hold. The memory read enable is deasserted so the read data is not lost.
- Advance (stall=0, redirect_valid=0):
  - if_instr <= mem[pc] and if_pc <= pc.
  - if_valid <= 1.
  - pc <= pc+1 modulo 2**ADDR_W, so pc wraps from 2**ADDR_W-1 to 0.
  - fetch_count increments by 1 unless saturated.
- Memory writes: when imem_we=1, mem[imem_waddr] <= imem_wdata on the edge, independent of stall and redirect. Read-during-write to the same address returns the old data (read-first).
- There is no stored valid state beyond if_valid. A flushed slot is a bubble that decode must ignore.

## Timing
- Fetch latency is 1 cycle: the instruction at address pc appears on if_instr the cycle after an advance edge.
- After reset release, the first edge with stall=0 gives if_valid=1 and if_pc=RESET_PC.
- Redirect penalty is 1 bubble: on the edge after redirect, if_valid=0. On the next advance edge, if_pc=redirect_pc.
- stall is sampled only at clock edges. Outputs stay stable for the whole stalled cycle.
- If reset is asserted mid-stall or mid-redirect, the reset values apply immediately and pending actions are discarded.

## Structure
- Shared package cpu_pkg holds the defaults IMEM_ADDR_W=7 and INSTR_W=32, the typedefs instr_t and imem_addr_t, and RESET_PC_DEFAULT.
- Sub-module imem_sync_ram holds the memory: a DEPTH x DATA_W array with one synchronous read port (with enable), one write port, and read-first behaviour.
- The top level holds the PC register, the output valid/PC register, the saturating counter, and the priority logic.

## Test plan
- Reset, then load mem[0..3]=0x11,0x22,0x33,0x44 and release with stall=0: the cycle after the first edge shows if_valid=1, if_pc=0, if_instr=0x11. The next three cycles show 0x22, 0x33, 0x44, and fetch_count=4.
- Assert stall for 3 cycles while if_instr=0x22: if_instr, if_pc and pc hold and fetch_count stays at 2. After release, 0x33 follows.
- Redirect to 0x40 while fetching address 2 (mem[0x40]=0xAA): the next cycle has if_valid=0 and pc=0x40. The following cycle has if_pc=0x40 and if_instr=0xAA.
- Assert redirect_valid=1 and stall=1 on the same edge: the redirect wins, so pc=redirect_pc and if_valid=0.
- Set pc=127 via redirect with mem[127]=0xFF and mem[0]=0x11: the sequence delivered is 0xFF then 0x11, with pc wrapping to 0 then 1.
- Write mem[5]=0xBEEF on the same edge that reads address 5 (old value 0x55): if_instr=0x55. Redirecting to 5 later returns 0xBEEF. Asserting reset mid-sequence clears all outputs asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU defaults and types for the instruction fetch path.
//            Holds the default instruction memory geometry, the reset fetch
//            address, and a saturating-increment helper for event counters.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          IMEM_ADDR_W      = 7;
    localparam int          INSTR_W          = 32;
    localparam int unsigned RESET_PC_DEFAULT = 0;

    typedef logic [IMEM_ADDR_W-1:0] imem_addr_t;
    typedef logic [INSTR_W-1:0]     instr_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_sync_ram.sv
`default_nettype none
// ============================================================================
// Module   : imem_sync_ram
// Purpose  : DEPTH x DATA_W instruction memory, one synchronous read port with
//            enable and one write port. Read-first on an address collision.
//            The read data register is reset; the array contents are not.
// Ports    : clk      - clock
//            reset    - asynchronous active-low reset (read register only)
//            rd_en    - read enable; when low, rd_data holds its value
//            rd_addr  - read word address
//            rd_data  - registered read data
//            wr_en    - write enable
//            wr_addr  - write word address
//            wr_data  - write data
// Revision : 1.0 - initial release
// ============================================================================
module imem_sync_ram
    import cpu_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // The array has no reset so it maps onto block RAM and keeps the program
    // image across a CPU reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Both updates are non-blocking on the same edge, so a read that hits the
    // address being written returns the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Pipelined fetch stage. Owns the fetch PC and the instruction
//            memory, delivers one registered instruction per cycle with its
//            PC and a valid bit. Redirect beats stall, stall beats advance.
// Ports    : clk            - clock
//            reset          - asynchronous active-low reset
//            stall          - decode back-pressure, holds everything
//            redirect_valid - taken branch/jump, loads redirect_pc, flushes
//            redirect_pc    - redirect target word address
//            imem_we        - program-load write enable
//            imem_waddr     - program-load write address
//            imem_wdata     - program-load write data
//            pc             - address being read this cycle
//            if_valid       - if_pc/if_instr hold a live instruction
//            if_pc          - address of if_instr
//            if_instr       - fetched instruction
//            fetch_count    - instructions delivered, saturating
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = IMEM_ADDR_W,
    parameter int          DATA_W   = INSTR_W,
    parameter int unsigned RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [DATA_W-1:0] imem_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic [31:0]       fetch_count
);

    // A redirect or a stall must leave if_instr untouched, so the memory read
    // register only loads on a plain advance.
    logic advance;
    assign advance = !redirect_valid && !stall;

    imem_sync_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (advance),
        .rd_addr (pc),
        .rd_data (if_instr),
        .wr_en   (imem_we),
        .wr_addr (imem_waddr),
        .wr_data (imem_wdata)
    );

    // Fetch PC; the add wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // Output qualifier and PC, aligned with the read data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (advance) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
        end else if (advance) begin
            fetch_count <= sat_inc32(fetch_count);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Self-checking bench for instruction_fetch_unit. A driver applies
//            directed then random stimulus, steps a behavioural model and
//            queues the expected outputs; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_we = 1'b0;
    logic [AW-1:0] imem_waddr = '0;
    logic [DW-1:0] imem_wdata = '0;
    logic [AW-1:0] pc;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [DW-1:0] if_instr;
    logic [31:0]   fetch_count;

    instruction_fetch_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .pc             (pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          v;
        logic [AW-1:0] ipc;
        logic [DW-1:0] instr;
        logic [31:0]   cnt;
    } obs_t;

    obs_t sb_q[$];
    int   tests  = 0;
    int   failed = 0;

    // Reference model state
    int unsigned   m_mem [DEPTH];
    int unsigned   m_pc, m_ipc, m_instr;
    longint        m_cnt;
    bit            m_valid;
    bit            rst_v = 1'b0;

    function automatic obs_t model_obs();
        obs_t o;
        o.pc    = AW'(m_pc);
        o.v     = m_valid;
        o.ipc   = AW'(m_ipc);
        o.instr = m_instr;
        o.cnt   = 32'(m_cnt);
        return o;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ipc = 0; m_instr = 0; m_cnt = 0; m_valid = 0;
    endtask

    // One clock: drive inputs, step the model, queue the expectation.
    task automatic cycle(input bit st, input bit rv, input int unsigned rp,
                         input bit we, input int unsigned wa, input int unsigned wd);
        reset          = rst_v;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = AW'(rp);
        imem_we        = we;
        imem_waddr     = AW'(wa);
        imem_wdata     = wd;
        if (!rst_v) begin
            model_reset();
        end else if (rv) begin
            m_pc    = rp % DEPTH;
            m_valid = 0;
        end else if (!st) begin
            m_instr = m_mem[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 1) % DEPTH;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        if (we) m_mem[wa % DEPTH] = wd;
        sb_q.push_back(model_obs());
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset between edges and check that it takes effect at once.
    task automatic async_reset_check(input string tag);
        obs_t act;
        #2;
        reset = 1'b0;
        rst_v = 1'b0;
        model_reset();
        #1;
        act = {pc, if_valid, if_pc, if_instr, fetch_count};
        tests++;
        if (act !== model_obs()) begin
            failed++;
            $display("FAIL async_reset_%s: got pc=%0h v=%0b ipc=%0h instr=%0h cnt=%0d, want all zero",
                     tag, act.pc, act.v, act.ipc, act.instr, act.cnt);
        end
        cycle(1, 1, 9, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        rst_v = 1'b1;
    endtask

    // Monitor: compare every queued expectation against the sampled outputs.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {pc, if_valid, if_pc, if_instr, fetch_count};
                tests++;
                if (a !== e) begin
                    failed++;
                    $display("FAIL scoreboard t=%0t: got pc=%0h v=%0b ipc=%0h instr=%0h cnt=%0d, want pc=%0h v=%0b ipc=%0h instr=%0h cnt=%0d",
                             $time, a.pc, a.v, a.ipc, a.instr, a.cnt,
                             e.pc, e.v, e.ipc, e.instr, e.cnt);
                end
            end
        end
    end

    initial begin
        int unsigned img [DEPTH];
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
        img[5] = 32'h55; img[32'h40] = 32'hAA; img[127] = 32'hFF;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hDEAD_0000;
        model_reset();

        @(negedge clk);
        #1;
        // Program load under reset; outputs must stay at reset values.
        rst_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1, i, img[i]);
        rst_v = 1'b1;

        // Basic stream with a 3-cycle stall while 0x22 is presented.
        adv(); adv();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        adv(); adv();

        // Redirect to 0x40, then redirect with stall on the same edge to 127
        // to exercise the wrap.
        cycle(0, 1, 32'h40, 0, 0, 0);
        adv();
        cycle(1, 1, 127, 0, 0, 0);
        adv(); adv(); adv();

        // Read-first collision at address 5, then re-read the new word.
        cycle(0, 1, 5, 0, 0, 0);
        cycle(0, 0, 0, 1, 5, 32'hBEEF);
        cycle(0, 1, 5, 0, 0, 0);
        adv();

        // Reset in the middle of a stall.
        cycle(1, 0, 0, 0, 0, 0);
        async_reset_check("stall");
        adv(); adv();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit          st, rv, we;
            int unsigned rp;
            st = ($urandom % 4) == 0;
            rv = ($urandom % 7) == 0;
            rp = (($urandom % 3) == 0) ? (124 + $urandom % 4) : ($urandom % DEPTH);
            we = ($urandom % 5) == 0;
            cycle(st, rv, rp, we, $urandom % DEPTH, $urandom);
            if (i == 200) begin
                cycle(0, 1, 77, 0, 0, 0);
                async_reset_check("redirect");
            end
        end

        @(negedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard bound in case the driver never completes.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
